// File: rtl/aes_ecb_blk_packer.sv
// aes_ecb_blk_packer: gathers a 32-bit word stream into 128-bit AES blocks,
// zero-pads the final partial block and tags each block with the message
// key, mode, valid-bit count and last marker. One output holding register
// plus the assembly register give two blocks of back-pressure depth.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_RUN  | assembly register accepting words; no completed block waiting
// ST_PEND | completed block parked in assembly, output slot busy, s_ready=0
module aes_ecb_blk_packer #(
  parameter int KEY_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [KEY_W-1:0]  cfg_key,
  input  logic              cfg_mode,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  input  logic [2:0]        s_nbytes,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [127:0]      m_block,
  output logic [KEY_W-1:0]  m_key,
  output logic              m_mode,
  output logic [7:0]        m_bits,
  output logic              m_last,
  output logic [15:0]       blk_count,
  output logic              err_nbytes
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               rst_q;
  logic [127:0]       asm_q;
  logic [1:0]         widx_q;
  logic               in_msg_q;
  logic [KEY_W-1:0]   key_q;
  logic               mode_q;
  logic [7:0]         pend_bits_q;
  logic               pend_last_q;

  logic               m_valid_q;
  logic [127:0]       m_block_q;
  logic [KEY_W-1:0]   m_key_q;
  logic               m_mode_q;
  logic [7:0]         m_bits_q;
  logic               m_last_q;
  logic [15:0]        blk_count_q;
  logic               err_q;

  logic               blk_pend;
  logic               acc;
  logic               out_fire;
  logic               slot_free;
  logic               blk_done;
  logic               nb_bad;
  logic [2:0]         nb_eff;
  logic [31:0]        word_masked;
  logic [127:0]       blk_new;
  logic [7:0]         bits_new;
  logic [KEY_W-1:0]   cur_key;
  logic               cur_mode;

  assign blk_pend  = (state_q == ST_PEND);
  assign s_ready   = !blk_pend && !rst_q;
  assign acc       = s_valid && s_ready;
  assign out_fire  = m_valid_q && m_ready;
  assign slot_free = !m_valid_q || m_ready;
  assign blk_done  = acc && (s_last || (widx_q == 2'd3));

  // A block with the first word of a message uses the live config,
  // later blocks use the copy latched on that first word.
  assign cur_key  = in_msg_q ? key_q  : cfg_key;
  assign cur_mode = in_msg_q ? mode_q : cfg_mode;

  // Byte count of the current word: illegal counts on a last word act as 4.
  always_comb begin
    nb_bad = s_last && ((s_nbytes == 3'd0) || (s_nbytes > 3'd4));
    nb_eff = 3'd4;
    if (s_last && !nb_bad) begin
      nb_eff = s_nbytes;
    end
  end

  // Zero the bytes beyond the valid count on the last word.
  always_comb begin
    word_masked = s_data;
    for (int b = 0; b < 4; b++) begin
      if (s_last && (3'(b) >= nb_eff)) begin
        word_masked[8*b +: 8] = 8'h00;
      end
    end
  end

  // Candidate block: lanes below widx keep prior words, lane widx takes the
  // new word, lanes above are forced to zero.
  always_comb begin
    blk_new = '0;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) < widx_q) begin
        blk_new[32*i +: 32] = asm_q[32*i +: 32];
      end else if (2'(i) == widx_q) begin
        blk_new[32*i +: 32] = word_masked;
      end
    end
  end

  // Valid-bit count: 32 per full lane before widx plus the last-word bytes.
  always_comb begin
    bits_new = 8'd128;
    if (s_last) begin
      bits_new = {1'b0, widx_q, 5'b0} + {2'b0, nb_eff, 3'b0};
    end
  end

  // State register and reset-shadow used to hold s_ready low in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rst_q   <= 1'b0;
    end
  end

  // Park a completed block when the output slot is busy; release it on
  // the output handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (blk_done && !slot_free) state_d = ST_PEND;
      ST_PEND: if (out_fire)               state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Message tracking: word index, in-message flag, key/mode latch, error.
  always_ff @(posedge clk) begin
    if (rst) begin
      widx_q   <= 2'd0;
      in_msg_q <= 1'b0;
      key_q    <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (acc) begin
      widx_q   <= blk_done ? 2'd0 : widx_q + 2'd1;
      in_msg_q <= !s_last;
      if (!in_msg_q) begin
        key_q  <= cfg_key;
        mode_q <= cfg_mode;
      end
      if (nb_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  // Assembly register, pending-block tags and output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q       <= '0;
      pend_bits_q <= 8'd0;
      pend_last_q <= 1'b0;
      m_valid_q   <= 1'b0;
      m_block_q   <= '0;
      m_key_q     <= '0;
      m_mode_q    <= 1'b0;
      m_bits_q    <= 8'd0;
      m_last_q    <= 1'b0;
      blk_count_q <= 16'd0;
    end else begin
      if (out_fire) begin
        blk_count_q <= blk_count_q + 16'd1;
      end
      if (blk_pend && out_fire) begin
        m_valid_q <= 1'b1;
        m_block_q <= asm_q;
        m_key_q   <= key_q;
        m_mode_q  <= mode_q;
        m_bits_q  <= pend_bits_q;
        m_last_q  <= pend_last_q;
        asm_q     <= '0;
      end else if (blk_done && slot_free) begin
        m_valid_q <= 1'b1;
        m_block_q <= blk_new;
        m_key_q   <= cur_key;
        m_mode_q  <= cur_mode;
        m_bits_q  <= bits_new;
        m_last_q  <= s_last;
        asm_q     <= '0;
      end else if (blk_done) begin
        asm_q       <= blk_new;
        pend_bits_q <= bits_new;
        pend_last_q <= s_last;
      end else begin
        if (out_fire) begin
          m_valid_q <= 1'b0;
        end
        if (acc) begin
          asm_q <= blk_new;
        end
      end
    end
  end

  assign m_valid    = m_valid_q;
  assign m_block    = m_block_q;
  assign m_key      = m_key_q;
  assign m_mode     = m_mode_q;
  assign m_bits     = m_bits_q;
  assign m_last     = m_last_q;
  assign blk_count  = blk_count_q;
  assign err_nbytes = err_q;

endmodule

// File: tb/tb_aes_ecb_blk_packer.sv
// Directed bench for aes_ecb_blk_packer with hand-computed expected blocks.
module tb_aes_ecb_blk_packer;

  localparam int KEY_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic [KEY_W-1:0]  cfg_key;
  logic              cfg_mode;
  logic              s_valid;
  logic              s_ready;
  logic [31:0]       s_data;
  logic              s_last;
  logic [2:0]        s_nbytes;
  logic              m_valid;
  logic              m_ready;
  logic [127:0]      m_block;
  logic [KEY_W-1:0]  m_key;
  logic              m_mode;
  logic [7:0]        m_bits;
  logic              m_last;
  logic [15:0]       blk_count;
  logic              err_nbytes;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0]     q_blk[$];
  logic [KEY_W-1:0] q_key[$];
  logic             q_mode[$];
  logic [7:0]       q_bits[$];
  logic             q_last[$];

  localparam logic [KEY_W-1:0] K1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [KEY_W-1:0] K2 = 128'hFFEEDDCCBBAA99887766554433221100;
  localparam logic [KEY_W-1:0] K3 = 128'h0123456789ABCDEF0123456789ABCDEF;

  aes_ecb_blk_packer #(.KEY_W(KEY_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_key    (cfg_key),
    .cfg_mode   (cfg_mode),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_nbytes   (s_nbytes),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_block    (m_block),
    .m_key      (m_key),
    .m_mode     (m_mode),
    .m_bits     (m_bits),
    .m_last     (m_last),
    .blk_count  (blk_count),
    .err_nbytes (err_nbytes)
  );

  always #5 clk = ~clk;

  // Record every block that will hand off on the coming rising edge.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      q_blk.push_back(m_block);
      q_key.push_back(m_key);
      q_mode.push_back(m_mode);
      q_bits.push_back(m_bits);
      q_last.push_back(m_last);
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    int t;
    s_valid  = 1'b1;
    s_data   = d;
    s_last   = last;
    s_nbytes = nb;
    t = 0;
    while (!s_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) begin
      check("s_ready_timeout", 0, 1);
    end else begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [127:0] blk, input logic [7:0] bits,
                           input logic last, input logic [KEY_W-1:0] key, input logic mode);
    int t;
    t = 0;
    while (q_blk.size() == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (q_blk.size() == 0) begin
      check({tag, "_timeout"}, 0, 1);
    end else begin
      check({tag, "_block"}, q_blk.pop_front(), blk);
      check({tag, "_bits"},  q_bits.pop_front(), bits);
      check({tag, "_last"},  q_last.pop_front(), last);
      check({tag, "_key"},   q_key.pop_front(), key);
      check({tag, "_mode"},  q_mode.pop_front(), mode);
    end
  endtask

  function automatic logic [31:0] bp_word(int b, int j);
    return 32'hA5000000 | 32'(b * 4 + j);
  endfunction

  initial begin
    logic [127:0] exp_blk;
    rst      = 1'b1;
    cfg_key  = K1;
    cfg_mode = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    s_nbytes = 3'd4;
    m_ready  = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_blk_count", blk_count, 0);
    check("rst_err", err_nbytes, 0);
    check("rst_m_bits", m_bits, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_s_ready", s_ready, 1);

    // Single full message
    send_word(32'h03020100, 1'b0, 3'd4);
    send_word(32'h07060504, 1'b0, 3'd4);
    send_word(32'h0B0A0908, 1'b0, 3'd4);
    send_word(32'h0F0E0D0C, 1'b1, 3'd4);
    check("latency_m_valid", m_valid, 1);
    pop_check("full", 128'h0F0E0D0C_0B0A0908_07060504_03020100, 8'd128, 1'b1, K1, 1'b1);
    @(posedge clk); #1;
    check("full_count", blk_count, 1);

    // Six-word message, key/mode change after the first word
    send_word(32'h03020100, 1'b0, 3'd4);
    cfg_key  = K2;
    cfg_mode = 1'b0;
    send_word(32'h07060504, 1'b0, 3'd4);
    send_word(32'h0B0A0908, 1'b0, 3'd4);
    send_word(32'h0F0E0D0C, 1'b0, 3'd4);
    send_word(32'h03020100, 1'b0, 3'd4);
    send_word(32'hAABBCCDD, 1'b1, 3'd1);
    pop_check("six_b1", 128'h0F0E0D0C_0B0A0908_07060504_03020100, 8'd128, 1'b0, K1, 1'b1);
    pop_check("six_b2", {64'h0, 32'h000000DD, 32'h03020100}, 8'd40, 1'b1, K1, 1'b1);
    @(posedge clk); #1;
    check("six_count", blk_count, 3);

    // Back-pressure: three full blocks under m_ready=0, new key K2
    m_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < 4; j++) begin
        if (b == 1 && j == 3) check("bp_ready_word7", s_ready, 1);
        send_word(bp_word(b, j), 1'b0, 3'd4);
      end
    end
    check("bp_ready_drop", s_ready, 0);
    exp_blk = {bp_word(0, 3), bp_word(0, 2), bp_word(0, 1), bp_word(0, 0)};
    check("bp_hold_block0", m_block, exp_blk);
    repeat (4) @(posedge clk);
    #1;
    check("bp_hold_block1", m_block, exp_blk);
    check("bp_hold_valid", m_valid, 1);
    check("bp_hold_ready", s_ready, 0);
    fork
      begin
        for (int j = 0; j < 4; j++) send_word(bp_word(2, j), j == 3, 3'd4);
      end
      begin
        repeat (3) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    for (int b = 0; b < 3; b++) begin
      exp_blk = {bp_word(b, 3), bp_word(b, 2), bp_word(b, 1), bp_word(b, 0)};
      pop_check($sformatf("bp_b%0d", b), exp_blk, 8'd128, b == 2, K2, 1'b0);
    end
    @(posedge clk); #1;
    check("bp_count", blk_count, 6);

    // Illegal byte count on the last word
    send_word(32'h11111111, 1'b0, 3'd4);
    send_word(32'h22222222, 1'b1, 3'd0);
    pop_check("nb0", {64'h0, 32'h22222222, 32'h11111111}, 8'd64, 1'b1, K2, 1'b0);
    @(posedge clk); #1;
    check("nb0_err", err_nbytes, 1);
    send_word(32'h44332211, 1'b1, 3'd3);
    pop_check("nb3", {96'h0, 32'h00332211}, 8'd24, 1'b1, K2, 1'b0);
    @(posedge clk); #1;
    check("nb3_err_sticky", err_nbytes, 1);
    check("nb_count", blk_count, 8);

    // Reset mid-message
    send_word(32'h55555555, 1'b0, 3'd4);
    send_word(32'h66666666, 1'b0, 3'd4);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_count", blk_count, 0);
    check("mid_rst_err", err_nbytes, 0);
    check("mid_rst_block", m_block, 0);
    check("mid_rst_key", m_key, 0);
    rst = 1'b0;
    cfg_key = K3;
    cfg_mode = 1'b1;
    @(posedge clk); #1;
    send_word(32'hDEADBEEF, 1'b1, 3'd2);
    pop_check("after_rst", {96'h0, 32'h0000BEEF}, 8'd16, 1'b1, K3, 1'b1);
    @(posedge clk); #1;
    check("after_rst_count", blk_count, 1);
    check("after_rst_queue_empty", q_blk.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_ecb_blk_packer.md
# aes_ecb_blk_packer

Upstream stage of the AES-ECB datapath. It accepts a 32-bit word stream with valid/ready and a last marker, and assembles 128-bit blocks with zero-padding on the final partial block. Each block is emitted together with the message key, the mode and a valid-bit count, in the same word/bit layout that the AES-ECB crypto engine and its DPI reference model consume. The block includes one output holding register, so the next block can be assembled while the previous block is back-pressured.

## Interface
- KEY_W, 128: key width in bits; legal values are 128, 192 and 256.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_key  in  KEY_W  key; sampled on the first accepted word of a message.
- cfg_mode  in  1  1 = encrypt, 0 = decrypt; sampled together with cfg_key.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word ready.
- s_data  in  32  input word; byte 0 is s_data[7:0].
- s_last  in  1  last word of the message.
- s_nbytes  in  3  number of valid bytes in the last word, 1..4; ignored when s_last=0.
- m_valid  out  1  output block valid.
- m_ready  in  1  output block ready.
- m_block  out  128  assembled block; word i occupies [32i+31:32i].
- m_key  out  KEY_W  key latched for the message.
- m_mode  out  1  mode latched for the message.
- m_bits  out  8  number of valid bits in m_block: 8..128, in multiples of 8.
- m_last  out  1  block is the last block of its message.
- blk_count  out  16  number of blocks emitted; wraps from 0xFFFF to 0.
- err_nbytes  out  1  sticky flag; set on an illegal s_nbytes value.

## Operation
- A word is accepted when s_valid and s_ready are both high. The word index widx (0..3) selects the target lane [32·widx+31:32·widx] of the assembly register.
- in_msg flag: set by the first accepted word of a message, cleared when a word with s_last=1 is accepted. The key and mode are latched only when a word is accepted while in_msg=0, and are held for every block of that message.
- A block completes when widx=3 is accepted or when s_last=1 is accepted.
- On the last word, bytes at positions s_nbytes..3 are forced to 0, and every higher word lane is forced to 0.
- m_bits = 32·widx + 8·s_nbytes on the last word; otherwise 128.
- s_nbytes values of 0, 5, 6 or 7 with s_last=1: treated as 4 and err_nbytes is set. err_nbytes clears only on rst.
- Handoff of a completed block:
  - Output slot free (m_valid=0, or m_ready=1 in the same cycle): the block moves to the output registers on the next edge.
  - Output slot busy: the block is held in assembly, blk_pend=1, and s_ready=0.
  - blk_pend clears on the edge where m_valid && m_ready; the pending block loads into the output on that same edge.
- s_ready = !blk_pend && !rst_q, where rst_q is high during reset.
- m_valid, m_block, m_key, m_mode, m_bits and m_last are stable while m_valid=1 && m_ready=0.
- blk_count increments on every m_valid && m_ready edge.
- widx resets to 0 after each completed block. The assembly register is cleared on completion, so unwritten lanes always read 0.
- If s_last arrives at widx=3, the result is a single full block with m_last=1 and m_bits = 96 + 8·nbytes.

## Timing
- Reset values: s_ready=0 while rst=1, then 1 on the first cycle after rst deasserts. m_valid, m_block, m_key, m_mode, m_bits, m_last, blk_count and err_nbytes are all 0. widx=0, in_msg=0, blk_pend=0.
- Latency: the completing word is accepted at edge N; m_valid=1 is visible after edge N.
- Throughput: one word per cycle sustained with m_ready held at 1; no bubble between blocks.
- Back-pressure depth is one held output block plus one assembled block. After that, s_ready stays low until m_ready.
- Reset asserted mid-message or mid-handshake discards all partial and held blocks. blk_count returns to 0.
- A completed block and an output consume on the same edge: the new block replaces the old one with no gap in m_valid.

## Test plan
- Reset, then 4 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with s_last on word 4, s_nbytes=4, and m_ready=1 -> one block:
  - m_block = 0x0F0E0D0C_0B0A0908_07060504_03020100
  - m_bits=128, m_last=1, blk_count=1
- 6-word message with the last word 0xAABBCCDD and s_nbytes=1 -> block 1: m_bits=128, m_last=0. Block 2:
  - m_block[31:0] = 0x03020100 (same word as block 1), m_block[63:32] = 0x000000DD, upper 64 bits = 0
  - m_bits=40, m_last=1
- Key change: cfg_key is changed between words of a message -> m_key equals the value at the first word for both blocks; the next message picks up the new key.
- Hold m_ready=0 through 3 consecutive full blocks -> s_ready drops after the 8th word is accepted. m_block is stable. Releasing m_ready delivers the blocks in order with no loss.
- s_last with s_nbytes=0 -> the word is treated as 4 bytes, m_bits is a multiple of 32, and err_nbytes=1 persists until rst.
- Assert rst after 2 words -> all outputs return to 0. A following 1-word message with s_nbytes=2 gives m_bits=16 and blk_count=1.
